// File: rtl/logic_op_pkg.sv
// Shared opcode encodings and response-slot state type for the logic-op arbiter.
// Optional feature macro used by the top: LOGIC_ARB_PERF_EN.
package logic_op_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'd0;
   localparam logic [OP_W-1:0] OP_OR   = 3'd1;
   localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
   localparam logic [OP_W-1:0] OP_NAND = 3'd3;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
   localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_t;

endpackage

// File: rtl/logic_unit.sv
// Combinational N-bit logic unit built from gate primitive arrays.
// Reserved opcode yields zero data with err raised.
module logic_unit
   import logic_op_pkg::*;
#(
   parameter int N = 1
) (
   input  logic [OP_W-1:0] op,
   input  logic [N-1:0]    a,
   input  logic [N-1:0]    b,
   output logic [N-1:0]    y,
   output logic            err
);

   logic [N-1:0] y_and;
   logic [N-1:0] y_or;
   logic [N-1:0] y_not;
   logic [N-1:0] y_nand;
   logic [N-1:0] y_nor;
   logic [N-1:0] y_xor;
   logic [N-1:0] y_xnor;

   and  g_and  [N-1:0] (y_and,  a, b);
   or   g_or   [N-1:0] (y_or,   a, b);
   not  g_not  [N-1:0] (y_not,  a);
   nand g_nand [N-1:0] (y_nand, a, b);
   nor  g_nor  [N-1:0] (y_nor,  a, b);
   xor  g_xor  [N-1:0] (y_xor,  a, b);
   xnor g_xnor [N-1:0] (y_xnor, a, b);

   always_comb begin
      y   = '0;
      err = 1'b0;
      case (op)
         OP_AND:  y = y_and;
         OP_OR:   y = y_or;
         OP_NOT:  y = y_not;
         OP_NAND: y = y_nand;
         OP_NOR:  y = y_nor;
         OP_XOR:  y = y_xor;
         OP_XNOR: y = y_xnor;
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic_unit among NREQ requesters, with a registered response.
// Define LOGIC_ARB_PERF_EN to add the saturating op_count accept counter.
module logic_op_arbiter
   import logic_op_pkg::*;
#(
   parameter int N    = 1,
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [OP_W*NREQ-1:0] req_op,
   input  logic [N*NREQ-1:0]    req_a,
   input  logic [N*NREQ-1:0]    req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [N-1:0]         rsp_data,
   output logic [IDW-1:0]       rsp_id,
   output logic                 rsp_err
`ifdef LOGIC_ARB_PERF_EN
   ,
   output logic [15:0]          op_count
`endif
);

   rsp_state_t      state;
   rsp_state_t      state_next;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  win;
   logic            found;
   logic            slot_free;
   logic            accept;
   logic [OP_W-1:0] sel_op;
   logic [N-1:0]    sel_a;
   logic [N-1:0]    sel_b;
   logic [N-1:0]    unit_y;
   logic            unit_err;

   // Search upward from the last winner, wrapping, so every requester is reached within NREQ grants.
   always_comb begin
      int idx;
      found  = 1'b0;
      win    = '0;
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int off = 1; off <= NREQ; off++) begin
         idx = (int'(rr_ptr) + off) % NREQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            win    = IDW'(idx);
            sel_op = req_op[OP_W*idx +: OP_W];
            sel_a  = req_a[N*idx +: N];
            sel_b  = req_b[N*idx +: N];
         end
      end
   end

   assign rsp_valid = (state == RSP_FULL);
   assign slot_free = !rsp_valid || rsp_ready;
   assign accept    = found && slot_free && !rst;

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[win] = 1'b1;
      end
   end

   logic_unit #(.N(N)) u_unit (
      .op  (sel_op),
      .a   (sel_a),
      .b   (sel_b),
      .y   (unit_y),
      .err (unit_err)
   );

   always_comb begin
      state_next = state;
      case (state)
         RSP_EMPTY: if (accept) state_next = RSP_FULL;
         RSP_FULL:  if (rsp_ready && !accept) state_next = RSP_EMPTY;
         default:   state_next = RSP_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RSP_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Payload only loads on accept; a pop without accept leaves stale data behind an empty slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_data <= '0;
         rsp_id   <= '0;
         rsp_err  <= 1'b0;
         rr_ptr   <= IDW'(NREQ - 1);
      end else if (accept) begin
         rsp_data <= unit_y;
         rsp_id   <= win;
         rsp_err  <= unit_err;
         rr_ptr   <= win;
      end
   end

`ifdef LOGIC_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         op_count <= '0;
      end else if (accept && (op_count != 16'hFFFF)) begin
         op_count <= op_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed self-checking bench for logic_op_arbiter with N=4, NREQ=4.
// The op_count scenario is included when LOGIC_ARB_PERF_EN is defined.
module tb_logic_op_arbiter;

   localparam int N    = 4;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [3*NREQ-1:0] req_op;
   logic [N*NREQ-1:0] req_a;
   logic [N*NREQ-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [N-1:0]      rsp_data;
   logic [IDW-1:0]    rsp_id;
   logic              rsp_err;
`ifdef LOGIC_ARB_PERF_EN
   logic [15:0]       op_count;
`endif

   int n_compared   = 0;
   int n_mismatched = 0;

   logic_op_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_err   (rsp_err)
`ifdef LOGIC_ARB_PERF_EN
      ,
      .op_count  (op_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic set_req(input int id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      req_valid[id]     = 1'b1;
      req_op[3*id +: 3] = op;
      req_a[4*id +: 4]  = a;
      req_b[4*id +: 4]  = b;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         n_compared++;
         if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_idle cycle %0d: ready=%b valid=%b expected ready=0000 valid=0", i, req_ready, rsp_valid);
         end
      end
      n_compared++;
      if (rsp_data !== 4'h0 || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_values: data=%h id=%0d err=%b expected 0/0/0", rsp_data, rsp_id, rsp_err);
      end
   endtask

   task automatic test_single();
      @(negedge clk);
      rsp_ready = 1'b1;
      set_req(0, 3'd5, 4'hC, 4'hA);
      #1;
      n_compared++;
      if (req_ready !== 4'b0001) begin
         n_mismatched++;
         $display("[TB] FAIL single_grant: ready=%b expected 0001", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      #1;
      n_compared++;
      if (rsp_valid !== 1'b1 || rsp_data !== 4'h6 || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL single_xor: valid=%b data=%h id=%0d err=%b expected 1/6/0/0", rsp_valid, rsp_data, rsp_id, rsp_err);
      end
      n_compared++;
      if (req_ready !== 4'b0000) begin
         n_mismatched++;
         $display("[TB] FAIL idle_ready: ready=%b expected 0000", req_ready);
      end
      @(negedge clk);
      #1;
      n_compared++;
      if (rsp_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL pop_empty: valid=%b expected 0", rsp_valid);
      end
   endtask

   task automatic test_round_robin();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b1;
      for (int r = 0; r < NREQ; r++) set_req(r, 3'd3, 4'hF, 4'hF);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_compared++;
         if (req_ready !== (4'b0001 << (i % 4))) begin
            n_mismatched++;
            $display("[TB] FAIL rr_grant %0d: ready=%b expected %b", i, req_ready, 4'b0001 << (i % 4));
         end
         @(negedge clk);
         #1;
         n_compared++;
         if (rsp_valid !== 1'b1 || rsp_id !== IDW'(i % 4) || rsp_data !== 4'h0 || rsp_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rr_rsp %0d: valid=%b id=%0d data=%h err=%b expected 1/%0d/0/0", i, rsp_valid, rsp_id, rsp_data, rsp_err, i % 4);
         end
      end
      req_valid = '0;
   endtask

   task automatic test_back_pressure();
      @(negedge clk);
      req_valid = '0;
      rsp_ready = 1'b1;
      set_req(1, 3'd1, 4'h8, 4'h1);
      #1;
      n_compared++;
      if (req_ready !== 4'b0010) begin
         n_mismatched++;
         $display("[TB] FAIL bp_first_grant: ready=%b expected 0010", req_ready);
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      set_req(0, 3'd0, 4'hF, 4'hF);
      set_req(1, 3'd0, 4'hF, 4'hF);
      set_req(2, 3'd0, 4'hF, 4'h3);
      set_req(3, 3'd0, 4'hF, 4'hF);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_compared++;
         if (rsp_valid !== 1'b1 || rsp_data !== 4'h9 || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin
            n_mismatched++;
            $display("[TB] FAIL bp_hold %0d: valid=%b data=%h id=%0d ready=%b expected 1/9/1/0000", i, rsp_valid, rsp_data, rsp_id, req_ready);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      n_compared++;
      if (req_ready !== 4'b0100) begin
         n_mismatched++;
         $display("[TB] FAIL bp_release_grant: ready=%b expected 0100", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      #1;
      n_compared++;
      if (rsp_valid !== 1'b1 || rsp_data !== 4'h3 || rsp_id !== 2'd2) begin
         n_mismatched++;
         $display("[TB] FAIL bp_release_rsp: valid=%b data=%h id=%0d expected 1/3/2", rsp_valid, rsp_data, rsp_id);
      end
   endtask

   task automatic test_ops();
      int         ids  [4] = '{3, 0, 1, 2};
      logic [2:0] ops  [4] = '{3'd7, 3'd2, 3'd4, 3'd6};
      logic [3:0] as   [4] = '{4'hF, 4'h5, 4'hC, 4'hC};
      logic [3:0] bs   [4] = '{4'hF, 4'hF, 4'hA, 4'hA};
      logic [3:0] exps [4] = '{4'h0, 4'hA, 4'h1, 4'h9};
      logic       errs [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req_valid = '0;
         set_req(ids[i], ops[i], as[i], bs[i]);
         #1;
         n_compared++;
         if (req_ready !== (4'b0001 << ids[i])) begin
            n_mismatched++;
            $display("[TB] FAIL op_grant %0d: ready=%b expected %b", i, req_ready, 4'b0001 << ids[i]);
         end
         @(negedge clk);
         req_valid = '0;
         #1;
         n_compared++;
         if (rsp_data !== exps[i] || rsp_err !== errs[i] || rsp_id !== IDW'(ids[i])) begin
            n_mismatched++;
            $display("[TB] FAIL op_result %0d: data=%h err=%b id=%0d expected %h/%b/%0d", i, rsp_data, rsp_err, rsp_id, exps[i], errs[i], ids[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_valid = '0;
      rsp_ready = 1'b0;
      set_req(3, 3'd0, 4'hF, 4'h5);
      #1;
      n_compared++;
      if (req_ready !== 4'b1000) begin
         n_mismatched++;
         $display("[TB] FAIL rmid_grant: ready=%b expected 1000", req_ready);
      end
      @(negedge clk);
      for (int r = 0; r < NREQ; r++) set_req(r, 3'd1, 4'h3, 4'h4);
      rsp_ready = 1'b1;
      rst = 1'b1;
      #1;
      n_compared++;
      if (rsp_valid !== 1'b1 || rsp_data !== 4'h5 || req_ready !== 4'b0000) begin
         n_mismatched++;
         $display("[TB] FAIL rmid_during: valid=%b data=%h ready=%b expected 1/5/0000", rsp_valid, rsp_data, req_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_compared++;
      if (rsp_valid !== 1'b0 || rsp_data !== 4'h0 || req_ready !== 4'b0001) begin
         n_mismatched++;
         $display("[TB] FAIL rmid_after: valid=%b data=%h ready=%b expected 0/0/0001", rsp_valid, rsp_data, req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      #1;
      n_compared++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 4'h7) begin
         n_mismatched++;
         $display("[TB] FAIL rmid_first_rsp: valid=%b id=%0d data=%h expected 1/0/7", rsp_valid, rsp_id, rsp_data);
      end
   endtask

`ifdef LOGIC_ARB_PERF_EN
   task automatic test_perf_count();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_compared++;
      if (op_count !== 16'h0000) begin
         n_mismatched++;
         $display("[TB] FAIL perf_reset: op_count=%h expected 0000", op_count);
      end
      rsp_ready = 1'b1;
      for (int r = 0; r < NREQ; r++) set_req(r, 3'd0, 4'hF, 4'hF);
      repeat (3) @(negedge clk);
      #1;
      n_compared++;
      if (op_count !== 16'd3) begin
         n_mismatched++;
         $display("[TB] FAIL perf_count3: op_count=%h expected 0003", op_count);
      end
      repeat (70000 - 3) @(negedge clk);
      #1;
      n_compared++;
      if (op_count !== 16'hFFFF) begin
         n_mismatched++;
         $display("[TB] FAIL perf_saturate: op_count=%h expected ffff", op_count);
      end
      req_valid = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_back_pressure();
      test_ops();
      test_reset_mid();
`ifdef LOGIC_ARB_PERF_EN
      test_perf_count();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
